psg_register_bank: RTL and testbench

//  Upstream write interface for the SN76489 core. Decodes the chip's byte-wide LATCH/DATA

---
 rtl/psg_pkg.sv | 21 ++
 rtl/psg_write_strobe.sv | 52 +++++
 rtl/psg_register_bank.sv | 90 +++++++++
 tb/tb_psg_register_bank.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared SN76489 register-bank definitions: channel numbering, register kinds,
// silent attenuation code and the latch record written by LATCH bytes.
package psg_pkg;

    localparam logic [1:0] CHAN_TONE0 = 2'd0;
    localparam logic [1:0] CHAN_TONE1 = 2'd1;
    localparam logic [1:0] CHAN_TONE2 = 2'd2;
    localparam logic [1:0] CHAN_NOISE = 2'd3;

    localparam logic TYPE_TONE = 1'b0;
    localparam logic TYPE_VOL  = 1'b1;

    localparam logic [3:0] ATTEN_SILENT = 4'hF;

    // Register last addressed by a LATCH byte; DATA bytes act on it.
    typedef struct packed {
        logic [1:0] chan;
        logic       kind;
    } latch_t;

endpackage

// File: rtl/psg_write_strobe.sv
// Write-strobe front end: rising-edge detect on wr, READY busy window after each
// accepted write, and a sticky overrun flag for writes dropped while busy.
module psg_write_strobe #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic wr,
    output logic ready,
    output logic accept,
    output logic overrun
);

    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    logic          wr_q;
    logic          ready_q;
    logic          overrun_q;
    logic [CW-1:0] busy_cnt_q;
    logic          wr_event;

    assign wr_event = wr & ~wr_q;
    assign accept   = wr_event & ready_q;
    assign ready    = ready_q;
    assign overrun  = overrun_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= 1'b0;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
            busy_cnt_q <= '0;
        end else begin
            wr_q <= wr;
            if (accept) begin
                ready_q    <= 1'b0;
                busy_cnt_q <= CW'(BUSY_CYCLES - 1);
            end else if (!ready_q) begin
                if (busy_cnt_q == '0) begin
                    ready_q <= 1'b1;
                end else begin
                    busy_cnt_q <= busy_cnt_q - 1'b1;
                end
            end
            if (wr_event && !ready_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/psg_register_bank.sv
// SN76489 LATCH/DATA byte decoder feeding the tone, attenuation and noise registers
// that drive the generators directly.
module psg_register_bank
    import psg_pkg::*;
#(
    parameter int TONE_FREQUENCY_BITS = 10,
    parameter int ATTENUATION_BITS    = 4,
    parameter int NOISE_CONTROL_BITS  = 3,
    parameter int BUSY_CYCLES         = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       data,
    input  logic                             wr,
    output logic                             ready,
    output logic [3*TONE_FREQUENCY_BITS-1:0] tone_freq,
    output logic [4*ATTENUATION_BITS-1:0]    attenuation,
    output logic [NOISE_CONTROL_BITS-1:0]    noise_ctrl,
    output logic                             noise_reset,
    output logic                             overrun
);

    logic [2:0][TONE_FREQUENCY_BITS-1:0] tone_q, tone_d;
    logic [3:0][ATTENUATION_BITS-1:0]    atten_q, atten_d;
    logic [NOISE_CONTROL_BITS-1:0]       noise_q, noise_d;
    latch_t                              latch_q, latch_d;
    latch_t                              target;
    logic                                noise_wr;
    logic                                noise_reset_q;
    logic                                accept;

    psg_write_strobe #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_strobe (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .ready  (ready),
        .accept (accept),
        .overrun(overrun)
    );

    // NOTE: every next-state value defaults to its current value first so no path infers a latch.
    always_comb begin
        tone_d   = tone_q;
        atten_d  = atten_q;
        noise_d  = noise_q;
        latch_d  = latch_q;
        noise_wr = 1'b0;
        target   = latch_q;
        if (accept) begin
            if (data[7]) begin
                latch_d = '{chan: data[6:5], kind: data[4]};
                target  = latch_d;
            end
            if (target.kind == TYPE_VOL) begin
                atten_d[target.chan] = data[ATTENUATION_BITS-1:0];
            end else if (target.chan == CHAN_NOISE) begin
                noise_d  = data[NOISE_CONTROL_BITS-1:0];
                noise_wr = 1'b1;
            end else if (data[7]) begin
                tone_d[target.chan][3:0] = data[3:0];
            end else begin
                tone_d[target.chan][TONE_FREQUENCY_BITS-1:4] = data[TONE_FREQUENCY_BITS-5:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tone_q        <= '0;
            atten_q       <= {4{ATTENUATION_BITS'(ATTEN_SILENT)}};
            noise_q       <= '0;
            latch_q       <= '{chan: CHAN_TONE0, kind: TYPE_TONE};
            noise_reset_q <= 1'b0;
        end else begin
            tone_q        <= tone_d;
            atten_q       <= atten_d;
            noise_q       <= noise_d;
            latch_q       <= latch_d;
            noise_reset_q <= noise_wr;
        end
    end

    assign tone_freq   = tone_q;
    assign attenuation = atten_q;
    assign noise_ctrl  = noise_q;
    assign noise_reset = noise_reset_q;

endmodule

// File: tb/tb_psg_register_bank.sv
// Scenario bench for psg_register_bank: expected register images are queued as
// each write is driven and compared once the write has taken effect.
module tb_psg_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        wr;
    logic        ready;
    logic [29:0] tone_freq;
    logic [15:0] attenuation;
    logic [2:0]  noise_ctrl;
    logic        noise_reset;
    logic        overrun;

    typedef struct packed {
        logic [29:0] tone;
        logic [15:0] atten;
        logic [2:0]  noise;
    } state_t;

    state_t sb[$];
    state_t e;
    int     checks = 0;
    int     errors = 0;

    psg_register_bank dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .wr         (wr),
        .ready      (ready),
        .tone_freq  (tone_freq),
        .attenuation(attenuation),
        .noise_ctrl (noise_ctrl),
        .noise_reset(noise_reset),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wr    = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b required=1", tag, ready);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        sb.push_back('{tone: 30'h0, atten: 16'hFFFF, noise: 3'b000});
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL reset_regs: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        checks++;
        if ({ready, overrun, noise_reset} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/overrun/noise_reset=%b required=100", {ready, overrun, noise_reset});
        end
    endtask

    task automatic test_tone();
        apply_reset();
        sb.push_back('{tone: 30'h00E, atten: 16'hFFFF, noise: 3'b000});
        send(8'h8E);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL tone_latch_low: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        wait_ready("tone1");
        sb.push_back('{tone: 30'h0FE, atten: 16'hFFFF, noise: 3'b000});
        send(8'h0F);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL tone_data_high: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        wait_ready("tone2");
        sb.push_back('{tone: 30'h0F3, atten: 16'hFFFF, noise: 3'b000});
        send(8'h83);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL tone_keep_high: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        wait_ready("tone3");
    endtask

    task automatic test_volume();
        apply_reset();
        sb.push_back('{tone: 30'h0, atten: 16'hF5FF, noise: 3'b000});
        send(8'hD5);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL vol_latch: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        wait_ready("vol1");
        sb.push_back('{tone: 30'h0, atten: 16'hF9FF, noise: 3'b000});
        send(8'h09);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl} !== e) begin
            errors++;
            $display("FAIL vol_data: actual=%h required=%h", {tone_freq, attenuation, noise_ctrl}, e);
        end
        wait_ready("vol2");
    endtask

    task automatic test_noise();
        apply_reset();
        sb.push_back('{tone: 30'h0, atten: 16'hFFFF, noise: 3'b110});
        send(8'hE6);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl, noise_reset} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL noise_latch: actual=%h pulse=%b required=%h pulse=1",
                     {tone_freq, attenuation, noise_ctrl}, noise_reset, e);
        end
        tick();
        checks++;
        if (noise_reset !== 1'b0) begin
            errors++;
            $display("FAIL noise_pulse1_width: noise_reset=%b required=0", noise_reset);
        end
        wait_ready("noise1");
        sb.push_back('{tone: 30'h0, atten: 16'hFFFF, noise: 3'b011});
        send(8'h03);
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl, noise_reset} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL noise_data: actual=%h pulse=%b required=%h pulse=1",
                     {tone_freq, attenuation, noise_ctrl}, noise_reset, e);
        end
        tick();
        checks++;
        if (noise_reset !== 1'b0) begin
            errors++;
            $display("FAIL noise_pulse2_width: noise_reset=%b required=0", noise_reset);
        end
        wait_ready("noise2");
    endtask

    task automatic test_busy();
        int low_cycles;
        int n;
        apply_reset();
        sb.push_back('{tone: 30'h001, atten: 16'hFFFF, noise: 3'b000});
        send(8'h81);
        low_cycles = ready ? 0 : 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!ready) low_cycles++;
        end
        data = 8'h82;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        if (!ready) low_cycles++;
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl, overrun} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL busy_drop: actual=%h overrun=%b required=%h overrun=1",
                     {tone_freq, attenuation, noise_ctrl}, overrun, e);
        end
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            if (!ready) low_cycles++;
        end
        checks++;
        if (low_cycles != 32) begin
            errors++;
            $display("FAIL busy_window: ready low %0d cycles required 32", low_cycles);
        end
        apply_reset();
        sb.push_back('{tone: 30'h0, atten: 16'hFFFA, noise: 3'b000});
        data = 8'h9A;
        wr   = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        wr = 1'b0;
        tick();
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl, overrun, ready} !== {e, 2'b01}) begin
            errors++;
            $display("FAIL held_wr_single: actual=%h overrun=%b ready=%b required=%h overrun=0 ready=1",
                     {tone_freq, attenuation, noise_ctrl}, overrun, ready, e);
        end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        send(8'h81);
        for (int i = 0; i < 9; i++) tick();
        data  = 8'hB3;
        wr    = 1'b1;
        reset = 1'b1;
        tick();
        wr    = 1'b0;
        reset = 1'b0;
        sb.push_back('{tone: 30'h0, atten: 16'hFFFF, noise: 3'b000});
        e = sb.pop_front();
        checks++;
        if ({tone_freq, attenuation, noise_ctrl, ready, overrun} !== {e, 2'b10}) begin
            errors++;
            $display("FAIL reset_mid_busy: actual=%h ready=%b overrun=%b required=%h ready=1 overrun=0",
                     {tone_freq, attenuation, noise_ctrl}, ready, overrun, e);
        end
        tick();
        checks++;
        if ({attenuation, ready} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_busy_after: atten=%h ready=%b required=ffff ready=1", attenuation, ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr    = 1'b0;
        data  = 8'h00;
        test_reset();
        test_tone();
        test_volume();
        test_noise();
        test_busy();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
